vga_term_ctrl: RTL
==================

VGA_TERM_CTRL -- requirements
Module: vga_term_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 71, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per screen (480/16).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port ascii_in, input, 8, character code from keyboard path.
REQ-006 SHALL have port ascii_valid, input, 1, ascii_in valid; held by source until accepted.
REQ-007 SHALL have port ascii_ready, output, 1, controller can accept a character.
REQ-008 SHALL have port wr_en, output, 1, text-buffer write strobe.
REQ-009 SHALL have port wr_addr, output, 12, text-buffer write address (row*COLS+col).
REQ-010 SHALL have port wr_data, output, 8, text-buffer write data.
REQ-011 SHALL have port rd_addr, output, 12, text-buffer read address (scroll copy).
REQ-012 SHALL have port rd_data, input, 8, text-buffer read data, valid one cycle after rd_addr.
REQ-013 SHALL have ports cur_col (output, 7) and cur_row (output, 5), current cursor position.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, PUT, BACK, SCROLL, CLR_ROW, CLR_ALL.
REQ-016 SHALL drive ascii_ready=1 only in IDLE; a character is accepted on a cycle with ascii_valid && ascii_ready.
REQ-017 Printable 0x20..0x7E: IDLE->PUT; in PUT wr_en=1 for one cycle, wr_addr=cursor address, wr_data=ascii_in (registered at accept); cursor advances.
REQ-018 Cursor advance: col<COLS-1 -> col+1; col==COLS-1 -> col=0 and newline rule.
REQ-019 Newline rule (also for 0x0D and 0x0A): col=0; row<ROWS-1 -> row+1, return to IDLE; row==ROWS-1 -> enter SCROLL, row unchanged.
REQ-020 0x08 (backspace): col>0 -> col-1; col==0,row>0 -> col=COLS-1,row-1; then BACK writes 8'h00 at new cursor for one cycle; at (0,0) no write, return to IDLE next cycle.
REQ-021 0x0C: enter CLR_ALL, write 8'h00 to addresses 0..ROWS*COLS-1, one per cycle, ascending, cursor set to (0,0).
REQ-022 Any other code: consumed, no write, cursor unchanged, IDLE next cycle.
REQ-023 SCROLL: pipelined copy, rd_addr=i+COLS in cycle k, wr_addr=i with wr_data=rd_data in cycle k+1, i=0..(ROWS-1)*COLS-1; one write per cycle after first.
REQ-024 After SCROLL, CLR_ROW writes 8'h00 to addresses (ROWS-1)*COLS..ROWS*COLS-1, then IDLE.
REQ-025 Printable char or newline on last row: the character write (PUT) SHALL complete before SCROLL begins.
REQ-026 wr_addr arithmetic SHALL be 12-bit unsigned; max address ROWS*COLS-1=2129; never written beyond.
REQ-027 wr_en SHALL be 0 in IDLE; wr_addr/wr_data don't-care when wr_en=0.
REQ-028 ascii_valid during busy SHALL be ignored (not consumed).

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, cur_col=0, cur_row=0, wr_en=0, busy=0, ascii_ready=1 from next cycle.
REQ-030 Reset mid-SCROLL/CLR SHALL abort immediately; buffer contents left as partially written; no auto-clear.

Structure
REQ-031 COLS, ROWS, and codes CHR_BS=0x08, CHR_LF=0x0A, CHR_FF=0x0C, CHR_CR=0x0D, CHR_BLANK=0x00 SHALL live in shared package/header vga_term_pkg.
REQ-032 Cursor position/advance logic SHALL be one sub-module vga_term_cursor (inc, newline, back, home; outputs col, row, addr, at_last_row).

Verification
REQ-033 Reset, send 0x41 -> single wr_en pulse, wr_addr=0, wr_data=0x41; cursor (col 1,row 0); ascii_ready low exactly 2 cycles.
REQ-034 Send 71 x 0x42 from (0,0) -> last write at addr 70; cursor (0,1).
REQ-035 Buffer preloaded with addr value mod 256, cursor (5,29), send 0x0D -> addr i holds old i+71 for i<2059, 2059..2129 = 0x00, cursor (0,29), busy high 2059+1+71 cycles (±1 documented).
REQ-036 Cursor (0,1), send 0x08 -> write 0x00 at addr 70, cursor (70,0); cursor (0,0), send 0x08 -> no write.
REQ-037 Send 0x0C -> 2130 writes of 0x00 to addrs 0..2129, cursor (0,0); send 0x07 -> no write, cursor unchanged.
REQ-038 Assert rst mid-SCROLL -> wr_en 0 and busy 0 next cycle, cursor (0,0), next 0x41 written at addr 0.

Source files
------------

// File: rtl/vga_term_pkg.sv
// Shared screen geometry, control codes and controller state encoding for the VGA text terminal.
package vga_term_pkg;

    localparam int COLS = 71;
    localparam int ROWS = 30;

    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_BLANK = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        BACK,
        SCROLL,
        CLR_ROW,
        CLR_ALL
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_term_cursor.sv
// Cursor position register with home/back/newline/advance moves; updates on the edge after a request.
// Priority home > back > newline > inc; buffer address is row*COLS+col, combinational from the registers.
module vga_term_cursor #(
    parameter int COLS = 71,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        newline,
    input  logic        back,
    input  logic        home,
    output logic [6:0]  col,
    output logic [4:0]  row,
    output logic [11:0] addr,
    output logic        at_last_row
);

    localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
    localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);
    localparam logic [11:0] COLS_W  = 12'(COLS);

    logic [6:0] col_q, col_d;
    logic [4:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home) begin
            col_d = '0;
            row_d = '0;
        end else if (back) begin
            if (col_q != '0) begin
                col_d = col_q - 7'd1;
            end else if (row_q != '0) begin
                col_d = COL_MAX;
                row_d = row_q - 5'd1;
            end
        end else if (newline || (inc && (col_q == COL_MAX))) begin
            // The bottom row never advances; the controller scrolls instead.
            col_d = '0;
            if (row_q != ROW_MAX) begin
                row_d = row_q + 5'd1;
            end
        end else if (inc) begin
            col_d = col_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign addr        = 12'(row_q) * COLS_W + 12'(col_q);
    assign at_last_row = (row_q == ROW_MAX);

endmodule

// File: rtl/vga_term_ctrl.sv
// Terminal controller: turns accepted characters into text-buffer writes, scrolls and clears.
// Printable char busy 2 cycles, scroll (ROWS-1)*COLS+1+COLS cycles; ascii_ready only in IDLE, so sources stall while busy.
module vga_term_ctrl #(
    parameter int COLS = vga_term_pkg::COLS,
    parameter int ROWS = vga_term_pkg::ROWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ascii_in,
    input  logic        ascii_valid,
    output logic        ascii_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [11:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    import vga_term_pkg::*;

    localparam logic [11:0] COLS_W   = 12'(COLS);
    localparam logic [11:0] SCR_N    = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] LAST_ADR = 12'(ROWS * COLS - 1);
    localparam logic [6:0]  COL_MAX  = 7'(COLS - 1);

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  char_q, char_d;
    logic        put_ph_q, put_ph_d;
    logic        scr_q, scr_d;

    logic        cur_inc, cur_newline, cur_back, cur_home;
    logic [11:0] cur_addr;
    logic        at_last_row;
    logic        at_origin;

    vga_term_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk         (clk),
        .rst         (rst),
        .inc         (cur_inc),
        .newline     (cur_newline),
        .back        (cur_back),
        .home        (cur_home),
        .col         (cur_col),
        .row         (cur_row),
        .addr        (cur_addr),
        .at_last_row (at_last_row)
    );

    assign at_origin   = (cur_col == '0) && (cur_row == '0);
    assign ascii_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        char_d      = char_q;
        put_ph_d    = 1'b0;
        scr_d       = scr_q;
        cur_inc     = 1'b0;
        cur_newline = 1'b0;
        cur_back    = 1'b0;
        cur_home    = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = cnt_q;
        wr_data     = CHR_BLANK;
        rd_addr     = '0;

        case (state_q)
            IDLE: begin
                if (ascii_valid) begin
                    cnt_d = '0;
                    if (is_printable(ascii_in)) begin
                        char_d  = ascii_in;
                        state_d = PUT;
                    end else if ((ascii_in == CHR_CR) || (ascii_in == CHR_LF)) begin
                        cur_newline = 1'b1;
                        if (at_last_row) state_d = SCROLL;
                    end else if (ascii_in == CHR_BS) begin
                        if (!at_origin) begin
                            cur_back = 1'b1;
                            state_d  = BACK;
                        end
                    end else if (ascii_in == CHR_FF) begin
                        cur_home = 1'b1;
                        state_d  = CLR_ALL;
                    end
                end
            end

            // Phase 0 writes and advances; phase 1 leaves time for the cursor register to settle.
            PUT: begin
                if (!put_ph_q) begin
                    wr_en    = 1'b1;
                    wr_addr  = cur_addr;
                    wr_data  = char_q;
                    cur_inc  = 1'b1;
                    put_ph_d = 1'b1;
                    scr_d    = at_last_row && (cur_col == COL_MAX);
                end else begin
                    state_d = scr_q ? SCROLL : IDLE;
                end
            end

            BACK: begin
                wr_en   = 1'b1;
                wr_addr = cur_addr;
                state_d = IDLE;
            end

            // Read runs one cycle ahead of the write to cover the buffer read latency.
            SCROLL: begin
                if (cnt_q != SCR_N) rd_addr = cnt_q + COLS_W;
                if (cnt_q != '0) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_q - 12'd1;
                    wr_data = rd_data;
                end
                if (cnt_q == SCR_N) begin
                    cnt_d   = '0;
                    state_d = CLR_ROW;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end

            CLR_ROW: begin
                wr_en   = 1'b1;
                wr_addr = SCR_N + cnt_q;
                if (cnt_q == COLS_W - 12'd1) state_d = IDLE;
                else                         cnt_d   = cnt_q + 12'd1;
            end

            CLR_ALL: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                if (cnt_q == LAST_ADR) state_d = IDLE;
                else                   cnt_d   = cnt_q + 12'd1;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            char_q   <= '0;
            put_ph_q <= 1'b0;
            scr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
            put_ph_q <= put_ph_d;
            scr_q    <= scr_d;
        end
    end

endmodule
